// File: rtl/ov_cap.sv
// ov_cap: captures one camera line, selected by cfg_line, into a byte FIFO.
// Software reads the FIFO, status and config registers over the fx bus.
module ov_cap #(
  parameter int unsigned AW = 10
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [7:0]  data_pclk,
  input  logic        data_vld,
  input  logic [15:0] cnt_line,
  input  logic [15:0] cnt_pclk,
  input  logic        fx_wr,
  input  logic [21:0] fx_waddr,
  input  logic [7:0]  fx_data,
  input  logic        fx_rd,
  input  logic [21:0] fx_raddr,
  output logic [7:0]  fx_q,
  input  logic [5:0]  dev_id
);

  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [1:0] {StIdle, StWaitLine, StCapture, StDone} state_e;

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [15:0] cnt_q;
  logic [15:0] cfg_line_q;
  logic [7:0]  pclk_q;
  logic        ovf_q;
  logic [7:0]  mem [Depth];

  logic wr_sel, rd_sel, start, pop, push, drop;
  logic line_match, empty, full, busy, done;

  // Only the low byte of the pixel index is reported.
  logic unused_pclk_hi;
  assign unused_pclk_hi = ^cnt_pclk[15:8];

  assign wr_sel     = fx_wr && (fx_waddr[21:16] == dev_id);
  assign rd_sel     = fx_rd && (fx_raddr[21:16] == dev_id);
  assign start      = wr_sel && (fx_waddr[15:0] == 16'h0000);
  assign line_match = (cnt_line == cfg_line_q);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Empty is judged before this cycle's push, so a pop never returns a same-cycle byte.
  assign pop        = rd_sel && (fx_raddr[15:0] == 16'h0010) && !empty;
  assign busy       = (state_q == StWaitLine) || (state_q == StCapture);
  assign done       = (state_q == StDone);

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and push/drop decisions; a start write overrides everything.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    if (start) begin
      state_d = StWaitLine;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StWaitLine: begin
          if (data_vld && line_match) begin
            state_d = StCapture;
            push    = 1'b1;
          end
        end
        StCapture: begin
          if (!line_match) begin
            state_d = StDone;
          end else if (data_vld) begin
            if (full) begin
              drop = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // FIFO pointers, byte count, overflow flag and last captured pixel index.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      pclk_q   <= '0;
    end else if (start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
        pclk_q   <= cnt_pclk[7:0];
        if (cnt_q != 16'hffff) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Line buffer storage; contents need no reset.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= data_pclk;
    end
  end

  // Configured line index, written a byte at a time.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cfg_line_q <= '0;
    end else if (wr_sel) begin
      if (fx_waddr[15:0] == 16'h0001) cfg_line_q[7:0]  <= fx_data;
      if (fx_waddr[15:0] == 16'h0002) cfg_line_q[15:8] <= fx_data;
    end
  end

  // Registered read data; holds across unmapped or unselected reads.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_q <= '0;
    end else if (rd_sel) begin
      case (fx_raddr[15:0])
        16'h0001: fx_q <= cfg_line_q[7:0];
        16'h0002: fx_q <= cfg_line_q[15:8];
        16'h0003: fx_q <= {4'b0000, empty, ovf_q, done, busy};
        16'h0004: fx_q <= cnt_q[7:0];
        16'h0005: fx_q <= cnt_q[15:8];
        16'h0006: fx_q <= pclk_q;
        16'h0010: fx_q <= empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];
        default:  fx_q <= fx_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ov_cap.sv
// Directed bench for ov_cap: line capture, overflow, restart, concurrent pop,
// device select and reset during capture.
module tb_ov_cap;

  localparam logic [5:0] DEV   = 6'h05;
  localparam logic [5:0] OTHER = 6'h33;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [7:0]  data_pclk;
  logic        data_vld;
  logic [15:0] cnt_line;
  logic [15:0] cnt_pclk;
  logic        fx_wr;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;
  logic [5:0]  dev_id;

  int n_pass  = 0;
  int n_total = 0;

  ov_cap #(.AW(10)) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .data_pclk(data_pclk),
    .data_vld (data_vld),
    .cnt_line (cnt_line),
    .cnt_pclk (cnt_pclk),
    .fx_wr    (fx_wr),
    .fx_waddr (fx_waddr),
    .fx_data  (fx_data),
    .fx_rd    (fx_rd),
    .fx_raddr (fx_raddr),
    .fx_q     (fx_q),
    .dev_id   (dev_id)
  );

  always #5 clk_sys = ~clk_sys;

  // All tasks start and end just after a falling edge.
  task automatic bus_write(input logic [15:0] off, input logic [7:0] d, input logic [5:0] id);
    fx_wr = 1'b1; fx_waddr = {id, off}; fx_data = d;
    @(negedge clk_sys);
    fx_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] off, input logic [5:0] id, output logic [7:0] q);
    fx_rd = 1'b1; fx_raddr = {id, off};
    @(negedge clk_sys);
    fx_rd = 1'b0;
    q = fx_q;
  endtask

  task automatic drive_line(input logic [15:0] line, input int n);
    for (int i = 0; i < n; i++) begin
      cnt_line = line; cnt_pclk = 16'(i); data_pclk = 8'(i); data_vld = 1'b1;
      @(negedge clk_sys);
    end
    data_vld = 1'b0;
  endtask

  task automatic set_line_and_start(input logic [15:0] line);
    bus_write(16'h0001, line[7:0], DEV);
    bus_write(16'h0002, line[15:8], DEV);
    bus_write(16'h0000, 8'h00, DEV);
  endtask

  task automatic test_reset;
    logic [7:0] q;
    rst_n = 1'b0; data_vld = 1'b0; data_pclk = '0; cnt_line = '0; cnt_pclk = '0;
    fx_wr = 1'b0; fx_rd = 1'b0; fx_waddr = '0; fx_raddr = '0; fx_data = '0; dev_id = DEV;
    repeat (3) @(negedge clk_sys);
    n_total++;
    if (fx_q !== 8'h00) $display("FAIL reset_fx_q: got %h expected 00", fx_q);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk_sys);
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h08) $display("FAIL reset_status: got %h expected 08", q);
    else n_pass++;
    bus_read(16'h0001, DEV, q);
    n_total++;
    if (q !== 8'h00) $display("FAIL reset_cfg_lo: got %h expected 00", q);
    else n_pass++;
    bus_read(16'h0004, DEV, q);
    n_total++;
    if (q !== 8'h00) $display("FAIL reset_cnt_lo: got %h expected 00", q);
    else n_pass++;
    bus_read(16'h0010, DEV, q);
    n_total++;
    if (q !== 8'h00) $display("FAIL reset_pop: got %h expected 00", q);
    else n_pass++;
  endtask

  task automatic test_capture_line;
    logic [7:0] q;
    set_line_and_start(16'd5);
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h09) $display("FAIL cap_status_wait: got %h expected 09", q);
    else n_pass++;
    for (int l = 0; l <= 6; l++) drive_line(16'(l), 640);
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h02) $display("FAIL cap_status_done: got %h expected 02", q);
    else n_pass++;
    bus_read(16'h0004, DEV, q);
    n_total++;
    if (q !== 8'h80) $display("FAIL cap_cnt_lo: got %h expected 80", q);
    else n_pass++;
    bus_read(16'h0005, DEV, q);
    n_total++;
    if (q !== 8'h02) $display("FAIL cap_cnt_hi: got %h expected 02", q);
    else n_pass++;
    bus_read(16'h0006, DEV, q);
    n_total++;
    if (q !== 8'h7f) $display("FAIL cap_pclk_lo: got %h expected 7f", q);
    else n_pass++;
    bus_read(16'h0001, DEV, q);
    n_total++;
    if (q !== 8'h05) $display("FAIL cap_cfg_lo: got %h expected 05", q);
    else n_pass++;
    for (int i = 0; i < 640; i++) begin
      bus_read(16'h0010, DEV, q);
      n_total++;
      if (q !== 8'(i)) $display("FAIL cap_pop[%0d]: got %h expected %h", i, q, 8'(i));
      else n_pass++;
    end
    bus_read(16'h0010, DEV, q);
    n_total++;
    if (q !== 8'h00) $display("FAIL cap_pop_empty: got %h expected 00", q);
    else n_pass++;
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h0a) $display("FAIL cap_status_empty: got %h expected 0a", q);
    else n_pass++;
  endtask

  task automatic test_overflow;
    logic [7:0] q;
    set_line_and_start(16'd2);
    drive_line(16'd1, 10);
    drive_line(16'd2, 1100);
    drive_line(16'd3, 1);
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h06) $display("FAIL ovf_status: got %h expected 06", q);
    else n_pass++;
    bus_read(16'h0004, DEV, q);
    n_total++;
    if (q !== 8'h00) $display("FAIL ovf_cnt_lo: got %h expected 00", q);
    else n_pass++;
    bus_read(16'h0005, DEV, q);
    n_total++;
    if (q !== 8'h04) $display("FAIL ovf_cnt_hi: got %h expected 04", q);
    else n_pass++;
    bus_read(16'h0006, DEV, q);
    n_total++;
    if (q !== 8'hff) $display("FAIL ovf_pclk_lo: got %h expected ff", q);
    else n_pass++;
    for (int i = 0; i < 1024; i++) begin
      bus_read(16'h0010, DEV, q);
      n_total++;
      if (q !== 8'(i)) $display("FAIL ovf_pop[%0d]: got %h expected %h", i, q, 8'(i));
      else n_pass++;
    end
    bus_read(16'h0010, DEV, q);
    n_total++;
    if (q !== 8'h00) $display("FAIL ovf_pop_empty: got %h expected 00", q);
    else n_pass++;
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h0e) $display("FAIL ovf_status_empty: got %h expected 0e", q);
    else n_pass++;
  endtask

  task automatic test_restart;
    logic [7:0] q;
    set_line_and_start(16'd3);
    drive_line(16'd3, 100);
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h01) $display("FAIL rst_status_cap: got %h expected 01", q);
    else n_pass++;
    bus_write(16'h0000, 8'h00, DEV);
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h09) $display("FAIL rst_status_restart: got %h expected 09", q);
    else n_pass++;
    bus_read(16'h0004, DEV, q);
    n_total++;
    if (q !== 8'h00) $display("FAIL rst_cnt_lo: got %h expected 00", q);
    else n_pass++;
    drive_line(16'd4, 10);
    drive_line(16'd3, 20);
    drive_line(16'd5, 1);
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h02) $display("FAIL rst_status_done: got %h expected 02", q);
    else n_pass++;
    bus_read(16'h0004, DEV, q);
    n_total++;
    if (q !== 8'h14) $display("FAIL rst_cnt_lo2: got %h expected 14", q);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      bus_read(16'h0010, DEV, q);
      n_total++;
      if (q !== 8'(i)) $display("FAIL rst_pop[%0d]: got %h expected %h", i, q, 8'(i));
      else n_pass++;
    end
  endtask

  // Bytes are 1..100 so a 00 return unambiguously marks an empty pop.
  task automatic test_back_to_back;
    logic [7:0] q;
    logic [7:0] got [$];
    set_line_and_start(16'd7);
    fx_rd = 1'b1; fx_raddr = {DEV, 16'h0010};
    for (int i = 0; i < 206; i++) begin
      cnt_line  = (i < 200) ? 16'd7 : 16'd8;
      data_vld  = (i < 200) && (i % 2 == 0);
      data_pclk = 8'(i / 2 + 1);
      cnt_pclk  = 16'(i / 2);
      @(negedge clk_sys);
      if (fx_q !== 8'h00) got.push_back(fx_q);
    end
    fx_rd = 1'b0; data_vld = 1'b0;
    n_total++;
    if (got.size() !== 100) $display("FAIL b2b_count: got %0d expected 100", got.size());
    else n_pass++;
    for (int i = 0; i < got.size() && i < 100; i++) begin
      n_total++;
      if (got[i] !== 8'(i + 1)) $display("FAIL b2b_order[%0d]: got %h expected %h", i, got[i],
                                         8'(i + 1));
      else n_pass++;
    end
    bus_read(16'h0004, DEV, q);
    n_total++;
    if (q !== 8'h64) $display("FAIL b2b_cnt_lo: got %h expected 64", q);
    else n_pass++;
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h0a) $display("FAIL b2b_status: got %h expected 0a", q);
    else n_pass++;
  endtask

  task automatic test_dev_select;
    logic [7:0] q;
    bus_read(16'h0001, DEV, q);
    n_total++;
    if (q !== 8'h07) $display("FAIL sel_cfg_before: got %h expected 07", q);
    else n_pass++;
    bus_write(16'h0001, 8'h33, OTHER);
    bus_write(16'h0000, 8'h00, OTHER);
    bus_read(16'h0003, OTHER, q);
    n_total++;
    if (q !== 8'h07) $display("FAIL sel_fx_q_hold: got %h expected 07", q);
    else n_pass++;
    bus_read(16'h0007, DEV, q);
    n_total++;
    if (q !== 8'h07) $display("FAIL sel_unmapped_hold: got %h expected 07", q);
    else n_pass++;
    bus_read(16'h0001, DEV, q);
    n_total++;
    if (q !== 8'h07) $display("FAIL sel_cfg_after: got %h expected 07", q);
    else n_pass++;
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h0a) $display("FAIL sel_status: got %h expected 0a", q);
    else n_pass++;
  endtask

  task automatic test_reset_in_capture;
    logic [7:0] q;
    set_line_and_start(16'd1);
    drive_line(16'd1, 50);
    bus_read(16'h0004, DEV, q);
    n_total++;
    if (q !== 8'h32) $display("FAIL ric_cnt_pre: got %h expected 32", q);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (fx_q !== 8'h00) $display("FAIL ric_fx_q_async: got %h expected 00", fx_q);
    else n_pass++;
    @(negedge clk_sys);
    rst_n = 1'b1;
    drive_line(16'd1, 30);
    drive_line(16'd2, 1);
    bus_read(16'h0003, DEV, q);
    n_total++;
    if (q !== 8'h08) $display("FAIL ric_status: got %h expected 08", q);
    else n_pass++;
    bus_read(16'h0004, DEV, q);
    n_total++;
    if (q !== 8'h00) $display("FAIL ric_cnt_lo: got %h expected 00", q);
    else n_pass++;
    bus_read(16'h0001, DEV, q);
    n_total++;
    if (q !== 8'h00) $display("FAIL ric_cfg_lo: got %h expected 00", q);
    else n_pass++;
    bus_read(16'h0006, DEV, q);
    n_total++;
    if (q !== 8'h00) $display("FAIL ric_pclk_lo: got %h expected 00", q);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_capture_line();
    test_overflow();
    test_restart();
    test_back_to_back();
    test_dev_select();
    test_reset_in_capture();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ov_cap.md
OV_CAP -- requirements
Module: ov_cap

Interface
REQ-001 Parameter: AW, default 10, log2 of line-buffer depth in bytes (DEPTH = 2^AW = 1024).
REQ-002 clk_sys  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 data_pclk  input  8  pixel byte from camera monitor, clk_sys domain.
REQ-005 data_vld  input  1  single-cycle strobe qualifying data_pclk.
REQ-006 cnt_line  input  16  current line index within frame from camera monitor.
REQ-007 cnt_pclk  input  16  pixel-byte index within current line (status only).
REQ-008 fx_wr, fx_waddr[21:0], fx_data[7:0]  input  fx bus write strobe, address, data.
REQ-009 fx_rd, fx_raddr[21:0]  input  fx bus read strobe, address.
REQ-010 fx_q  output  8  fx bus read data.
REQ-011 dev_id  input  6  block select; access decoded only when addr[21:16] == dev_id.

Function
REQ-012 Register map (addr[15:0]): 0x0000 act_cap_start (W, any data), 0x0001 cfg_line_lo (RW), 0x0002 cfg_line_hi (RW), 0x0003 stu_status (R: bit0 busy, bit1 done, bit2 ovf, bit3 empty), 0x0004 stu_cnt_lo (R), 0x0005 stu_cnt_hi (R), 0x0006 stu_pclk_lo (R, last cnt_pclk captured [7:0]), 0x0010 fifo_pop (R).
REQ-013 fx_q registered: value for a read at cycle N appears at cycle N+1 and holds until the next decoded read; unmapped or non-selected addresses leave fx_q unchanged.
REQ-014 FSM states IDLE, WAIT_LINE, CAPTURE, DONE; reset state IDLE.
REQ-015 Write to 0x0000 from any state: clear buffer pointers, stu_cnt, done, ovf; next state WAIT_LINE.
REQ-016 WAIT_LINE -> CAPTURE on the cycle data_vld=1 and cnt_line == cfg_line; that byte is stored.
REQ-017 CAPTURE: each data_vld with cnt_line == cfg_line pushes data_pclk, increments stu_cnt, latches cnt_pclk[7:0].
REQ-018 CAPTURE -> DONE when cnt_line != cfg_line (line ended); no byte stored in that cycle.
REQ-019 Buffer full in CAPTURE: byte dropped, ovf set, stu_cnt not incremented, state stays CAPTURE until line ends.
REQ-020 DONE: done=1, busy=0; remains until next act_cap_start; data_vld ignored in IDLE and DONE.
REQ-021 busy = 1 in WAIT_LINE and CAPTURE only.
REQ-022 Read of 0x0010 when not empty: returns head byte (at N+1) and advances read pointer; when empty: returns 0x00, pointers unchanged.
REQ-023 Push and pop in same cycle: both take effect; occupancy unchanged; pop of empty buffer never returns the byte pushed that cycle.
REQ-024 Pointers AW+1 bits; empty when equal, full when MSBs differ and low AW bits equal; wrap modulo 2^AW.
REQ-025 stu_cnt 16 bit, counts stored bytes, saturates at 0xFFFF.
REQ-026 cfg_line writes take effect next cycle; change while busy applies to subsequent comparisons.

Reset
REQ-027 On rst_n low: state IDLE, pointers 0, stu_cnt 0, done/ovf 0, cfg_line 0x0000, stu_pclk 0, fx_q 0x00; empty=1.
REQ-028 Reset deassertion mid-line: no capture until a new act_cap_start.

Verification
REQ-029 cfg_line=5, start, drive lines 0..6 with 640 vld bytes each (data = byte index[7:0]) -> done=1, stu_cnt=640, 640 pops return 0x00..0x7F..., then pop returns 0x00 with empty=1.
REQ-030 cfg_line=2, line of 1100 bytes -> stu_cnt=1024, ovf=1, first/last pops = bytes 0 and 1023.
REQ-031 Start during CAPTURE after 100 bytes -> status busy=1, stu_cnt=0, empty=1, capture restarts at next matching line.
REQ-032 Pop every cycle while capturing line with vld every 2 cycles -> no byte lost/duplicated, final stu_cnt equals bytes driven, order preserved.
REQ-033 Access with addr[21:16] != dev_id -> no register change, fx_q unchanged.
REQ-034 Assert rst_n low in CAPTURE -> all REQ-027 values next cycle, state IDLE; vld afterwards ignored.
